// File: rtl/pwm_carrier_sched_pkg.sv
// Shared types and constants for the PWM carrier scheduler.
//   PWMCOUNT_WIDTH : default carrier / period width
//   carr_mode_t    : carrier counting shape (raw code 3 folds to CARR_UP)
//   pwm_onoff_t    : channel enable level
//   sched_state_t  : sequencing FSM state, exported for observation
//   MASKSEL_*      : maskevent source selection codes
package pwm_carrier_sched_pkg;

  localparam int PWMCOUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    CARR_UP     = 2'd0,
    CARR_DOWN   = 2'd1,
    CARR_UPDOWN = 2'd2
  } carr_mode_t;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } pwm_onoff_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } sched_state_t;

  localparam logic [1:0] MASKSEL_NONE   = 2'd0;
  localparam logic [1:0] MASKSEL_ZERO   = 2'd1;
  localparam logic [1:0] MASKSEL_PERIOD = 2'd2;
  localparam logic [1:0] MASKSEL_BOTH   = 2'd3;

  // Fold the raw 2-bit mode input onto a legal mode; the unused code counts up.
  function automatic carr_mode_t norm_mode(input logic [1:0] m);
    case (m)
      2'd1:    return CARR_DOWN;
      2'd2:    return CARR_UPDOWN;
      default: return CARR_UP;
    endcase
  endfunction

endpackage

// File: rtl/pwm_carrier_sched_prescaler.sv
// Count-tick generator for the carrier.
//   clk, reset : system clock, synchronous active-high reset
//   run        : counting allowed; counter held at 0 otherwise
//   clr        : synchronous clear (phase resync)
//   prescale   : tick every prescale+1 clocks
//   tick       : combinational, high in the cycle the carrier should advance
module pwm_carrier_sched_prescaler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] prescale,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_cnt;

  // ">=" rather than "==" so a prescale shadow that shrinks below the current
  // count still produces a tick instead of running around the full range.
  assign tick = run && (div_cnt >= prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clr || !run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_carrier_sched.sv
// Carrier generator and start/stop/resync sequencer for one compare group.
//   clk, reset  : system clock, synchronous active-high reset
//   enable      : run request (level)
//   sync_en     : start waits for sync_in; sync_in while running resyncs phase
//   sync_in     : single-cycle phase sync pulse
//   carr_mode   : 0 up, 1 down, 2 up/down, 3 up (shadowed)
//   period      : carrier peak P (shadowed)
//   prescale    : tick every prescale+1 clocks (shadowed)
//   mask_sel    : maskevent source, bit0 zero, bit1 period (live)
//   carrier     : registered count; carr_dir 1 while counting down
//   zero_evt    : pulse when carrier becomes its start value
//   period_evt  : pulse when carrier becomes P
//   maskevent   : shadow-load strobe for the compare channels
//   pwm_onoff   : channel enable; busy: FSM not idle; state_dbg: FSM state
module pwm_carrier_sched
  import pwm_carrier_sched_pkg::*;
#(
  parameter int CNT_WIDTH = PWMCOUNT_WIDTH,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync_en,
  input  logic                 sync_in,
  input  logic [1:0]           carr_mode,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [DIV_WIDTH-1:0] prescale,
  input  logic [1:0]           mask_sel,
  output logic [CNT_WIDTH-1:0] carrier,
  output logic                 carr_dir,
  output logic                 zero_evt,
  output logic                 period_evt,
  output logic                 maskevent,
  output pwm_onoff_t           pwm_onoff,
  output logic                 busy,
  output sched_state_t         state_dbg
);

  sched_state_t         state, nxt_state;
  carr_mode_t           sh_mode, live_mode;
  logic [CNT_WIDTH-1:0] sh_period;
  logic [DIV_WIDTH-1:0] sh_prescale;
  logic [CNT_WIDTH-1:0] sh_start, live_start;

  logic [CNT_WIDTH-1:0] nxt_carrier, cnt_next;
  logic                 nxt_dir, dir_next;
  logic                 nxt_zero, nxt_period, nxt_mask;
  pwm_onoff_t           nxt_onoff;
  logic                 entry_load, shadow_load;
  logic                 run_active, resync, tick;
  logic                 ev_zero, ev_period;

  assign live_mode  = norm_mode(carr_mode);
  assign live_start = (live_mode == CARR_DOWN) ? period : '0;
  assign sh_start   = (sh_mode == CARR_DOWN) ? sh_period : '0;

  assign run_active = (state == ST_RUN) || (state == ST_STOPPING);
  assign resync     = run_active && sync_en && sync_in;

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  pwm_carrier_sched_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .run      (run_active),
    .clr      (resync),
    .prescale (sh_prescale),
    .tick     (tick)
  );

  // Next carrier value and direction for one natural tick.
  always_comb begin
    cnt_next = carrier;
    dir_next = carr_dir;
    case (sh_mode)
      CARR_DOWN: begin
        dir_next = 1'b1;
        if (carrier == '0 || carrier > sh_period) cnt_next = sh_period;
        else                                      cnt_next = carrier - CNT_WIDTH'(1);
      end
      CARR_UPDOWN: begin
        if (!carr_dir) begin
          if (carrier >= sh_period) begin
            // Turn around at the peak; with P=0 the carrier just holds 0.
            cnt_next = (sh_period == '0) ? '0 : sh_period - CNT_WIDTH'(1);
            dir_next = (cnt_next != '0);
          end else begin
            cnt_next = carrier + CNT_WIDTH'(1);
            dir_next = 1'b0;
          end
        end else begin
          cnt_next = (carrier == '0) ? '0 : carrier - CNT_WIDTH'(1);
          dir_next = (cnt_next != '0);
        end
      end
      default: begin
        dir_next = 1'b0;
        cnt_next = (carrier >= sh_period) ? '0 : carrier + CNT_WIDTH'(1);
      end
    endcase
  end

  assign ev_zero   = (cnt_next == sh_start);
  assign ev_period = (cnt_next == sh_period);

  // Sequencing FSM plus registered-output next values.
  always_comb begin
    nxt_state   = state;
    nxt_carrier = carrier;
    nxt_dir     = carr_dir;
    nxt_zero    = 1'b0;
    nxt_period  = 1'b0;
    nxt_mask    = 1'b0;
    nxt_onoff   = pwm_onoff;
    entry_load  = 1'b0;

    case (state)
      ST_IDLE: begin
        nxt_carrier = sh_start;
        nxt_dir     = 1'b0;
        nxt_onoff   = PWM_OFF;
        if (enable) nxt_state = ST_ARMED;
      end

      ST_ARMED: begin
        if (!enable) begin
          nxt_state = ST_IDLE;
        end else if (!sync_en || sync_in) begin
          // RUN entry: outputs reflect the freshly latched live settings.
          nxt_state   = ST_RUN;
          entry_load  = 1'b1;
          nxt_carrier = live_start;
          nxt_dir     = (live_mode == CARR_DOWN);
          nxt_zero    = 1'b1;
          nxt_period  = (live_start == period);
          nxt_mask    = 1'b1;
          nxt_onoff   = PWM_ON;
        end
      end

      default: begin // ST_RUN, ST_STOPPING
        if (resync) begin
          // Resync overrides a coincident tick, so only one zero pulse results.
          nxt_carrier = sh_start;
          nxt_dir     = (sh_mode == CARR_DOWN);
          nxt_zero    = 1'b1;
          nxt_period  = (sh_start == sh_period);
        end else if (tick) begin
          nxt_carrier = cnt_next;
          nxt_dir     = dir_next;
          nxt_zero    = ev_zero;
          nxt_period  = ev_period;
        end
        nxt_mask = (nxt_zero & mask_sel[0]) | (nxt_period & mask_sel[1]);

        if (state == ST_RUN) begin
          if (!enable) nxt_state = ST_STOPPING;
        end else if (enable) begin
          nxt_state = ST_RUN;
        end else if (nxt_zero) begin
          // Stop lands on the start value; no shadow load on the way out.
          nxt_state = ST_IDLE;
          nxt_onoff = PWM_OFF;
          nxt_mask  = 1'b0;
        end
      end
    endcase
  end

  // Shadows take the live inputs at RUN entry and at the end of every
  // maskevent cycle, so new settings apply from the following cycle.
  assign shadow_load = entry_load || (run_active && maskevent);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      carrier     <= '0;
      carr_dir    <= 1'b0;
      zero_evt    <= 1'b0;
      period_evt  <= 1'b0;
      maskevent   <= 1'b0;
      pwm_onoff   <= PWM_OFF;
      sh_mode     <= CARR_UP;
      sh_period   <= '0;
      sh_prescale <= '0;
    end else begin
      state      <= nxt_state;
      carrier    <= nxt_carrier;
      carr_dir   <= nxt_dir;
      zero_evt   <= nxt_zero;
      period_evt <= nxt_period;
      maskevent  <= nxt_mask;
      pwm_onoff  <= nxt_onoff;
      if (shadow_load) begin
        sh_mode     <= live_mode;
        sh_period   <= period;
        sh_prescale <= prescale;
      end
    end
  end

endmodule

// File: tb/tb_pwm_carrier_sched.sv
// Self-checking bench for pwm_carrier_sched: a vector table of
// {inputs, expected registered outputs one clock later}, then hand-written
// sequences for prescaling, stop/restart, sync arming, resync and reset.
module tb_pwm_carrier_sched;
  import pwm_carrier_sched_pkg::*;

  localparam int W  = 16;
  localparam int DW = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset, enable, sync_en, sync_in;
  logic [1:0]    carr_mode, mask_sel;
  logic [W-1:0]  period;
  logic [DW-1:0] prescale;
  logic [W-1:0]  carrier;
  logic          carr_dir, zero_evt, period_evt, maskevent, busy;
  pwm_onoff_t    pwm_onoff;
  sched_state_t  state_dbg;

  always #5 clk = ~clk;

  pwm_carrier_sched #(.CNT_WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sync_en    (sync_en),
    .sync_in    (sync_in),
    .carr_mode  (carr_mode),
    .period     (period),
    .prescale   (prescale),
    .mask_sel   (mask_sel),
    .carrier    (carrier),
    .carr_dir   (carr_dir),
    .zero_evt   (zero_evt),
    .period_evt (period_evt),
    .maskevent  (maskevent),
    .pwm_onoff  (pwm_onoff),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic          rst, en, sen, sin;
    logic [1:0]    mode;
    logic [W-1:0]  per;
    logic [DW-1:0] ps;
    logic [1:0]    ms;
    logic [W-1:0]  c;
    logic          d, z, p, m, on, b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic rst, en, sen, sin,
                     input logic [1:0] mode, input int per, input int ps,
                     input logic [1:0] ms, input int c,
                     input logic d, z, p, m, on, b);
    vec_t v;
    v.name = name; v.rst = rst; v.en = en; v.sen = sen; v.sin = sin;
    v.mode = mode; v.per = W'(per); v.ps = DW'(ps); v.ms = ms;
    v.c = W'(c); v.d = d; v.z = z; v.p = p; v.m = m; v.on = on; v.b = b;
    tbl.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic rst, en, sen, sin, input logic [1:0] mode,
                        input int per, input int ps, input logic [1:0] ms);
    reset = rst; enable = en; sync_en = sen; sync_in = sin;
    carr_mode = mode; period = W'(per); prescale = DW'(ps); mask_sel = ms;
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int ec,
                       input logic ed, ez, ep, em, eon, eb);
    checks++;
    if (carrier !== W'(ec) || carr_dir !== ed || zero_evt !== ez ||
        period_evt !== ep || maskevent !== em ||
        logic'(pwm_onoff) !== eon || busy !== eb) begin
      failures++;
      $display("FAIL %s: got car=%0d dir=%b z=%b p=%b m=%b on=%b busy=%b; want car=%0d dir=%b z=%b p=%b m=%b on=%b busy=%b",
               name, carrier, carr_dir, zero_evt, period_evt, maskevent,
               logic'(pwm_onoff), busy, ec, ed, ez, ep, em, eon, eb);
    end
  endtask

  // ---------------- scoreboard for the prescaled carrier ----------------
  logic [W-1:0] exp_q[$];

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    // UP, P=4, no maskevent source: forced entry strobe only.
    add("up_rst",    1,0,0,0, 2'd0,4,0,2'd0, 0, 0,0,0,0,0,0);
    add("up_armed",  0,1,0,0, 2'd0,4,0,2'd0, 0, 0,0,0,0,0,1);
    add("up_entry",  0,1,0,0, 2'd0,4,0,2'd0, 0, 0,1,0,1,1,1);
    add("up_c1",     0,1,0,0, 2'd0,4,0,2'd0, 1, 0,0,0,0,1,1);
    add("up_c2",     0,1,0,0, 2'd0,4,0,2'd0, 2, 0,0,0,0,1,1);
    add("up_c3",     0,1,0,0, 2'd0,4,0,2'd0, 3, 0,0,0,0,1,1);
    add("up_c4",     0,1,0,0, 2'd0,4,0,2'd0, 4, 0,0,1,0,1,1);
    add("up_wrap",   0,1,0,0, 2'd0,4,0,2'd0, 0, 0,1,0,0,1,1);
    add("up_c1b",    0,1,0,0, 2'd0,4,0,2'd0, 1, 0,0,0,0,1,1);
    // UPDOWN, P=3, maskevent on zero and period.
    add("ud_rst",    1,0,0,0, 2'd2,3,0,2'd3, 0, 0,0,0,0,0,0);
    add("ud_armed",  0,1,0,0, 2'd2,3,0,2'd3, 0, 0,0,0,0,0,1);
    add("ud_entry",  0,1,0,0, 2'd2,3,0,2'd3, 0, 0,1,0,1,1,1);
    add("ud_c1",     0,1,0,0, 2'd2,3,0,2'd3, 1, 0,0,0,0,1,1);
    add("ud_c2",     0,1,0,0, 2'd2,3,0,2'd3, 2, 0,0,0,0,1,1);
    add("ud_peak",   0,1,0,0, 2'd2,3,0,2'd3, 3, 0,0,1,1,1,1);
    add("ud_dn2",    0,1,0,0, 2'd2,3,0,2'd3, 2, 1,0,0,0,1,1);
    add("ud_dn1",    0,1,0,0, 2'd2,3,0,2'd3, 1, 1,0,0,0,1,1);
    add("ud_zero",   0,1,0,0, 2'd2,3,0,2'd3, 0, 0,1,0,1,1,1);
    add("ud_up1",    0,1,0,0, 2'd2,3,0,2'd3, 1, 0,0,0,0,1,1);
    // UP, P=4 -> 2 changed mid-period; takes effect after the zero maskevent.
    add("pc_rst",    1,0,0,0, 2'd0,4,0,2'd1, 0, 0,0,0,0,0,0);
    add("pc_armed",  0,1,0,0, 2'd0,4,0,2'd1, 0, 0,0,0,0,0,1);
    add("pc_entry",  0,1,0,0, 2'd0,4,0,2'd1, 0, 0,1,0,1,1,1);
    add("pc_c1",     0,1,0,0, 2'd0,4,0,2'd1, 1, 0,0,0,0,1,1);
    add("pc_c2",     0,1,0,0, 2'd0,4,0,2'd1, 2, 0,0,0,0,1,1);
    add("pc_c3",     0,1,0,0, 2'd0,2,0,2'd1, 3, 0,0,0,0,1,1);
    add("pc_c4",     0,1,0,0, 2'd0,2,0,2'd1, 4, 0,0,1,0,1,1);
    add("pc_wrap",   0,1,0,0, 2'd0,2,0,2'd1, 0, 0,1,0,1,1,1);
    add("pc_n1",     0,1,0,0, 2'd0,2,0,2'd1, 1, 0,0,0,0,1,1);
    add("pc_n2",     0,1,0,0, 2'd0,2,0,2'd1, 2, 0,0,1,0,1,1);
    add("pc_nwrap",  0,1,0,0, 2'd0,2,0,2'd1, 0, 0,1,0,1,1,1);
    // P=0: carrier holds 0, both events every tick, one maskevent.
    add("p0_rst",    1,0,0,0, 2'd0,0,0,2'd3, 0, 0,0,0,0,0,0);
    add("p0_armed",  0,1,0,0, 2'd0,0,0,2'd3, 0, 0,0,0,0,0,1);
    add("p0_entry",  0,1,0,0, 2'd0,0,0,2'd3, 0, 0,1,1,1,1,1);
    add("p0_t1",     0,1,0,0, 2'd0,0,0,2'd3, 0, 0,1,1,1,1,1);
    add("p0_t2",     0,1,0,0, 2'd0,0,0,2'd3, 0, 0,1,1,1,1,1);
    // DOWN, P=2: start value is P.
    add("dn_rst",    1,0,0,0, 2'd1,2,0,2'd1, 0, 0,0,0,0,0,0);
    add("dn_armed",  0,1,0,0, 2'd1,2,0,2'd1, 0, 0,0,0,0,0,1);
    add("dn_entry",  0,1,0,0, 2'd1,2,0,2'd1, 2, 1,1,1,1,1,1);
    add("dn_c1",     0,1,0,0, 2'd1,2,0,2'd1, 1, 1,0,0,0,1,1);
    add("dn_c0",     0,1,0,0, 2'd1,2,0,2'd1, 0, 1,0,0,0,1,1);
    add("dn_wrap",   0,1,0,0, 2'd1,2,0,2'd1, 2, 1,1,1,1,1,1);

    foreach (tbl[i]) begin
      set_in(tbl[i].rst, tbl[i].en, tbl[i].sen, tbl[i].sin, tbl[i].mode,
             int'(tbl[i].per), int'(tbl[i].ps), tbl[i].ms);
      step();
      check(tbl[i].name, int'(tbl[i].c), tbl[i].d, tbl[i].z, tbl[i].p,
            tbl[i].m, tbl[i].on, tbl[i].b);
    end

    // prescale=2: every carrier value is held for 3 clocks.
    set_in(1, 0, 0, 0, 2'd0, 4, 2, 2'd0);
    step();
    set_in(0, 1, 0, 0, 2'd0, 4, 2, 2'd0);
    step();
    for (int v = 0; v < 4; v++)
      for (int k = 0; k < 3; k++) exp_q.push_back(W'(v));
    step();
    check("ps_entry", 0, 0, 1, 0, 1, 1, 1);
    step();
    check("ps_zero_single", 0, 0, 0, 0, 0, 1, 1);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      step();
      e = exp_q.pop_front();
      checks++;
      if (carrier !== e) begin
        failures++;
        $display("FAIL ps_hold: got car=%0d want car=%0d", carrier, e);
      end
    end

    // Drop enable at carrier=2: finish the period, switch off at zero.
    set_in(1, 0, 0, 0, 2'd0, 4, 0, 2'd1);
    step();
    set_in(0, 1, 0, 0, 2'd0, 4, 0, 2'd1);
    step(); step(); step(); step();
    check("stop_c2", 2, 0, 0, 0, 0, 1, 1);
    enable = 1'b0;
    step(); check("stop_c3",  3, 0, 0, 0, 0, 1, 1);
    step(); check("stop_c4",  4, 0, 0, 1, 0, 1, 1);
    step(); check("stop_off", 0, 0, 1, 0, 0, 0, 0);
    step(); check("stop_idle", 0, 0, 0, 0, 0, 0, 0);
    // Restart, drop enable, then re-raise it while stopping.
    enable = 1'b1;
    step(); step(); step(); step();
    check("restart_c2", 2, 0, 0, 0, 0, 1, 1);
    enable = 1'b0;
    step(); check("restop_c3", 3, 0, 0, 0, 0, 1, 1);
    enable = 1'b1;
    step(); check("rerun_c4",   4, 0, 0, 1, 0, 1, 1);
    step(); check("rerun_wrap", 0, 0, 1, 0, 1, 1, 1);

    // sync_en=1: ARMED waits for sync_in; resync in RUN; reset mid-run.
    set_in(1, 0, 0, 0, 2'd0, 4, 0, 2'd0);
    step();
    set_in(0, 1, 1, 0, 2'd0, 4, 0, 2'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check("armed_hold", 0, 0, 0, 0, 0, 0, 1);
    end
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("sync_entry", 0, 0, 1, 0, 1, 1, 1);
    step(); step(); step();
    check("sync_c3", 3, 0, 0, 0, 0, 1, 1);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("resync_c3", 0, 0, 1, 0, 0, 1, 1);
    step(); check("resync_c1", 1, 0, 0, 0, 0, 1, 1);
    step(); step(); step();
    check("pre_wrap_c4", 4, 0, 0, 1, 0, 1, 1);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("resync_at_wrap", 0, 0, 1, 0, 0, 1, 1);
    step(); check("single_zero", 1, 0, 0, 0, 0, 1, 1);
    step(); step();
    check("pre_reset_c3", 3, 0, 0, 0, 0, 1, 1);
    reset = 1'b1;
    step(); check("reset_midrun", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    enable = 1'b0;
    step(); check("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
